// File: rtl/led_pssr_pkg.sv
// Shared types and helpers for the LED frame serializer.
package led_pssr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_t;

  // Counter width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/led_pssr_shifter.sv
// Loadable WIDTH-bit shift register with zero fill; bit_out is the next bit on the line.
module led_pssr_shifter #(
  parameter int WIDTH     = 32,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             shift,
  output logic             bit_out
);

  logic [WIDTH-1:0] sreg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sreg <= '0;
    end else if (load) begin
      sreg <= din;
    end else if (shift) begin
      if (MSB_FIRST) sreg <= {sreg[WIDTH-2:0], 1'b0};
      else           sreg <= {1'b0, sreg[WIDTH-1:1]};
    end
  end

  assign bit_out = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];

endmodule

// File: rtl/led_frame_serializer.sv
// Double-buffered frame serializer: shadow bank behind valid/ready, working bank
// streamed channel by channel with shift strobe, per-channel latch and frame done.
module led_frame_serializer
  import led_pssr_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int WIDTH     = 32,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          frame_valid,
  output logic                          frame_ready,
  input  logic [N_CH*WIDTH-1:0]         frame_data,
  output logic                          data_out,
  output logic                          data_valid,
  output logic [clog2_min1(N_CH)-1:0]   ch_idx,
  output logic                          latch,
  output logic                          frame_done,
  output logic                          busy,
  output state_t                        fsm_state
);

  localparam int CW = clog2_min1(N_CH);
  localparam int BW = clog2_min1(WIDTH);

  state_t                state, state_nx;
  logic                  shadow_full;
  logic [N_CH*WIDTH-1:0] shadow, working;
  logic [CW-1:0]         ch, ch_nx;
  logic [BW-1:0]         bit_cnt, bit_cnt_nx;
  logic                  transfer, load, shift, accept;
  logic [WIDTH-1:0]      load_word;

  // Handshake: a frame transfers on any edge where frame_valid && frame_ready;
  // ready depends only on shadow occupancy and rst, never on frame_valid.
  assign frame_ready = !shadow_full && !rst;
  assign accept      = frame_valid && frame_ready;
  assign ch_idx      = ch;
  assign busy        = (state != IDLE);
  assign fsm_state   = state;

  always_comb begin
    state_nx   = state;
    ch_nx      = ch;
    bit_cnt_nx = bit_cnt;
    transfer   = 1'b0;
    load       = 1'b0;
    shift      = 1'b0;
    case (state)
      IDLE: begin
        if (shadow_full) begin
          transfer   = 1'b1;
          load       = 1'b1;
          ch_nx      = '0;
          bit_cnt_nx = '0;
          state_nx   = SHIFT;
        end
      end
      SHIFT: begin
        shift      = 1'b1;
        bit_cnt_nx = bit_cnt + BW'(1);
        if (bit_cnt == BW'(WIDTH-1)) state_nx = LATCH;
      end
      LATCH: begin
        if (ch != CW'(N_CH-1)) begin
          load       = 1'b1;
          ch_nx      = ch + CW'(1);
          bit_cnt_nx = '0;
          state_nx   = SHIFT;
        end else if (shadow_full) begin
          transfer   = 1'b1;
          load       = 1'b1;
          ch_nx      = '0;
          bit_cnt_nx = '0;
          state_nx   = SHIFT;
        end else begin
          state_nx   = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    // A transfer loads channel 0 straight from the shadow bank.
    load_word = transfer ? shadow[WIDTH-1:0] : working[int'(ch_nx)*WIDTH +: WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ch          <= '0;
      bit_cnt     <= '0;
      shadow_full <= 1'b0;
      shadow      <= '0;
      working     <= '0;
      data_valid  <= 1'b0;
      latch       <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      state      <= state_nx;
      ch         <= ch_nx;
      bit_cnt    <= bit_cnt_nx;
      data_valid <= (state_nx == SHIFT);
      latch      <= (state_nx == LATCH);
      frame_done <= (state_nx == LATCH) && (ch_nx == CW'(N_CH-1));
      if (transfer) working <= shadow;
      if (accept) begin
        shadow      <= frame_data;
        shadow_full <= 1'b1;
      end else if (transfer) begin
        shadow_full <= 1'b0;
      end
    end
  end

  // Zero fill leaves the shifter empty during LATCH and IDLE, so data_out is 0 there.
  led_pssr_shifter #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shifter (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .din     (load_word),
    .shift   (shift),
    .bit_out (data_out)
  );

endmodule
